// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared widths and source-select encoding for the writeback unit
// Rev 1.0
// ============================================================================
package wb_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;

    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_LOAD = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : small count-based FIFO with a combinational head read
// Rev 1.0
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == C_DEPTH);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only read when count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// writeback_unit : arbitrates ALU/load results onto one register-file write
//                  port and tracks outstanding destination registers
// Rev 1.0
// ============================================================================
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  load_valid,
    input  logic [REG_ADDR_W-1:0] load_rd,
    input  logic [XLEN-1:0]       load_data,
    output logic                  load_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic [NUM_REGS-1:0]   pending
);

    localparam int ENTRY_W = REG_ADDR_W + XLEN;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]      alu_count, load_count;
    logic                  alu_empty, load_empty;
    logic                  alu_push, load_push;
    logic                  alu_pop, load_pop;
    logic [ENTRY_W-1:0]    alu_head, load_head, sel_head;
    logic                  deq;
    wb_src_e               sel_src;

    wb_src_e               last_grant_q, last_grant_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    // Ready is held low for the whole reset window, otherwise it reflects
    // the registered occupancy only.
    assign alu_ready  = rst_n && (alu_count < C_DEPTH);
    assign load_ready = rst_n && (load_count < C_DEPTH);
    assign alu_push   = alu_valid && alu_ready;
    assign load_push  = load_valid && load_ready;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_push),
        .push_data ({alu_rd, alu_data}),
        .pop       (alu_pop),
        .head_data (alu_head),
        .empty     (alu_empty),
        .count     (alu_count)
    );

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (load_push),
        .push_data ({load_rd, load_data}),
        .pop       (load_pop),
        .head_data (load_head),
        .empty     (load_empty),
        .count     (load_count)
    );

    // Round-robin only matters when both heads compete.
    always_comb begin
        deq     = 1'b0;
        sel_src = SRC_ALU;
        if (!alu_empty && !load_empty) begin
            deq     = 1'b1;
            sel_src = (last_grant_q == SRC_ALU) ? SRC_LOAD : SRC_ALU;
        end else if (!alu_empty) begin
            deq     = 1'b1;
            sel_src = SRC_ALU;
        end else if (!load_empty) begin
            deq     = 1'b1;
            sel_src = SRC_LOAD;
        end
        alu_pop      = deq && (sel_src == SRC_ALU);
        load_pop     = deq && (sel_src == SRC_LOAD);
        sel_head     = (sel_src == SRC_LOAD) ? load_head : alu_head;
        last_grant_d = deq ? sel_src : last_grant_q;
    end

    always_comb begin
        reg_write_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        if (deq) begin
            rd_addr_d   = sel_head[ENTRY_W-1 -: REG_ADDR_W];
            rd_data_d   = sel_head[XLEN-1:0];
            reg_write_d = (sel_head[ENTRY_W-1 -: REG_ADDR_W] != '0);
        end

        // Clear first so a same-register issue on this edge wins.
        pending_d = pending_q;
        if (reg_write_d) begin
            pending_d[rd_addr_d] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_ALU;
            reg_write_q  <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            pending_q    <= pending_d;
        end
    end

    assign reg_write = reg_write_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// tb_writeback_unit : directed table, corner sequences and random traffic
//                     checked against a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_writeback_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } beat_t;

    typedef struct {
        logic            av;
        logic [4:0]      ard;
        logic [XLEN-1:0] ad;
        logic            lv;
        logic [4:0]      lrd;
        logic [XLEN-1:0] ld;
        logic            iv;
        logic [4:0]      ird;
    } stim_t;

    typedef struct {
        stim_t           s;
        logic            e_rw;
        logic            chk_ad;
        logic [4:0]      e_addr;
        logic [XLEN-1:0] e_data;
        logic [31:0]     e_pend;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            alu_valid, load_valid, issue_valid;
    logic [4:0]      alu_rd, load_rd, issue_rd;
    logic [XLEN-1:0] alu_data, load_data;
    logic            alu_ready, load_ready;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [31:0]     pending;

    int checks   = 0;
    int failures = 0;

    writeback_unit #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .load_valid  (load_valid),
        .load_rd     (load_rd),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .reg_write   (reg_write),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pending     (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: two queues, a "load went last" flag and a bit set.
    beat_t           mq_alu[$];
    beat_t           mq_ld[$];
    bit              m_last_load;
    bit              m_rw;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    logic [31:0]     m_pend;
    bit              m_a_acc, m_l_acc;
    int              dut_writes;
    bit              saw_stall;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_alu.delete();
        mq_ld.delete();
        m_last_load = 1'b0;
        m_rw        = 1'b0;
        m_addr      = '0;
        m_data      = '0;
        m_pend      = '0;
    endtask

    task automatic model_step(input stim_t s);
        beat_t b;
        int    pick;  // 0 none, 1 alu, 2 load
        m_a_acc = s.av && (mq_alu.size() < DEPTH);
        m_l_acc = s.lv && (mq_ld.size() < DEPTH);
        if (mq_alu.size() > 0 && mq_ld.size() > 0) pick = m_last_load ? 1 : 2;
        else if (mq_alu.size() > 0)                pick = 1;
        else if (mq_ld.size() > 0)                 pick = 2;
        else                                       pick = 0;
        m_rw = 1'b0;
        if (pick != 0) begin
            b = (pick == 1) ? mq_alu.pop_front() : mq_ld.pop_front();
            m_last_load = (pick == 2);
            if (b.rd != 0) begin
                m_rw   = 1'b1;
                m_addr = b.rd;
                m_data = b.data;
            end
        end
        if (m_rw) m_pend[m_addr] = 1'b0;
        if (s.iv && s.ird != 0) m_pend[s.ird] = 1'b1;
        if (m_a_acc) mq_alu.push_back('{rd: s.ard, data: s.ad});
        if (m_l_acc) mq_ld.push_back('{rd: s.lrd, data: s.ld});
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0};
        return s;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input stim_t s);
        alu_valid   = s.av;  alu_rd  = s.ard; alu_data  = s.ad;
        load_valid  = s.lv;  load_rd = s.lrd; load_data = s.ld;
        issue_valid = s.iv;  issue_rd = s.ird;
        #1;
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, mq_alu.size() < DEPTH});
        chk("load_ready", {63'd0, load_ready}, {63'd0, mq_ld.size() < DEPTH});
        if (!alu_ready || !load_ready) saw_stall = 1'b1;
        @(posedge clk);
        model_step(s);
        #1;
        if (reg_write) dut_writes++;
        chk("reg_write", {63'd0, reg_write}, {63'd0, m_rw});
        if (m_rw) begin
            chk("rd_addr", {59'd0, rd_addr}, {59'd0, m_addr});
            chk("rd_data", rd_data, m_data);
        end
        chk("pending", {32'd0, pending}, {32'd0, m_pend});
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_reg_write"}, {63'd0, reg_write}, '0);
        chk({tag, "_rd_addr"}, {59'd0, rd_addr}, '0);
        chk({tag, "_rd_data"}, rd_data, '0);
        chk({tag, "_pending"}, {32'd0, pending}, '0);
        chk({tag, "_alu_ready"}, {63'd0, alu_ready}, '0);
        chk({tag, "_load_ready"}, {63'd0, load_ready}, '0);
    endtask

    // Asserts reset between clock edges, checks immediate effect, releases at a falling edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        alu_valid = 1'b0; load_valid = 1'b0; issue_valid = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[14];

    initial begin
        stim_t s;
        int    ai, li, guard;

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        load_valid = 1'b0; load_rd = '0; load_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        dut_writes = 0;
        saw_stall  = 1'b0;
        model_reset();

        // Fields: {av ard ad lv lrd ld iv ird} e_rw chk_ad e_addr e_data e_pend
        vecs[0]  = '{'{1, 5, 64'h2A, 0, 0, 0, 1, 5}, 0, 0, 0, 0, 32'h0000_0020};
        vecs[1]  = '{'{0, 0, 0, 0, 0, 0, 0, 0},      1, 1, 5, 64'h2A, 32'h0};
        vecs[2]  = '{'{0, 0, 0, 0, 0, 0, 0, 0},      0, 1, 5, 64'h2A, 32'h0};
        vecs[3]  = '{'{1, 0, 64'hFFFF, 0, 0, 0, 0, 0}, 0, 0, 0, 0, 32'h0};
        vecs[4]  = '{'{0, 0, 0, 0, 0, 0, 0, 0},      0, 0, 0, 0, 32'h0};
        vecs[5]  = '{'{1, 3, 64'h33, 1, 7, 64'h77, 1, 3}, 0, 0, 0, 0, 32'h8};
        vecs[6]  = '{'{0, 0, 0, 0, 0, 0, 1, 3},      1, 1, 7, 64'h77, 32'h8};
        vecs[7]  = '{'{0, 0, 0, 0, 0, 0, 1, 3},      1, 1, 3, 64'h33, 32'h8};
        vecs[8]  = '{'{0, 0, 0, 0, 0, 0, 1, 0},      0, 1, 3, 64'h33, 32'h8};
        vecs[9]  = '{'{1, 3, 64'h99, 0, 0, 0, 0, 0}, 0, 0, 0, 0, 32'h8};
        vecs[10] = '{'{0, 0, 0, 0, 0, 0, 0, 0},      1, 1, 3, 64'h99, 32'h0};
        vecs[11] = '{'{1, 10, 64'h5678, 1, 9, 64'h1234, 0, 0}, 0, 0, 0, 0, 32'h0};
        vecs[12] = '{'{0, 0, 0, 0, 0, 0, 0, 0},      1, 1, 9, 64'h1234, 32'h0};
        vecs[13] = '{'{0, 0, 0, 0, 0, 0, 0, 0},      1, 1, 10, 64'h5678, 32'h0};

        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].s);
            chk($sformatf("vec%0d_reg_write", i), {63'd0, reg_write}, {63'd0, vecs[i].e_rw});
            if (vecs[i].chk_ad) begin
                chk($sformatf("vec%0d_rd_addr", i), {59'd0, rd_addr}, {59'd0, vecs[i].e_addr});
                chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_data);
            end
            chk($sformatf("vec%0d_pending", i), {32'd0, pending}, {32'd0, vecs[i].e_pend});
        end

        // Both sources offer rd 1..8 continuously, each beat held until accepted.
        pulse_reset("rst_a");
        dut_writes = 0;
        saw_stall  = 1'b0;
        ai = 1; li = 1; guard = 0;
        while ((ai <= 8 || li <= 8 || mq_alu.size() > 0 || mq_ld.size() > 0) && guard < 100) begin
            s = idle();
            s.av = (ai <= 8); s.ard = 5'(ai); s.ad = 64'hA00 + 64'(ai);
            s.lv = (li <= 8); s.lrd = 5'(li); s.ld = 64'hB00 + 64'(li);
            cycle(s);
            if (m_a_acc) ai++;
            if (m_l_acc) li++;
            guard++;
        end
        chk("stream_budget", {63'd0, guard < 100}, 64'd1);
        chk("stream_writes", 64'(dut_writes), 64'd16);
        chk("stream_stall_seen", {63'd0, saw_stall}, 64'd1);

        // Fill both queues with pending bits set, then reset mid-cycle.
        for (int i = 0; i < 4; i++) begin
            s = idle();
            s.av = 1'b1; s.ard = 5'(20 + i); s.ad = 64'hC0 + 64'(i);
            s.lv = 1'b1; s.lrd = 5'(24 + i); s.ld = 64'hD0 + 64'(i);
            s.iv = 1'b1; s.ird = 5'(12 + i);
            cycle(s);
        end
        pulse_reset("rst_mid");
        dut_writes = 0;
        for (int i = 0; i < 4; i++) cycle(idle());
        chk("post_reset_no_writes", 64'(dut_writes), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            s.av  = ($urandom_range(0, 3) != 0);
            s.ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.ad  = {$urandom, $urandom};
            s.lv  = ($urandom_range(0, 3) != 0);
            s.lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.ld  = {$urandom, $urandom};
            s.iv  = ($urandom_range(0, 1) != 0);
            s.ird = 5'($urandom_range(0, 31));
            cycle(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the result data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the entries per source queue; legal values are 2 or 4.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have ports alu_valid  input  1, alu_rd  input  5, alu_data  input  XLEN, alu_ready  output  1, meaning the ALU result channel.
REQ-006 The block SHALL have ports load_valid  input  1, load_rd  input  5, load_data  input  XLEN, load_ready  output  1, meaning the load result channel.
REQ-007 The block SHALL have ports issue_valid  input  1, issue_rd  input  5, meaning the destination register claimed by an issued instruction.
REQ-008 The block SHALL have ports reg_write  output  1, rd_addr  output  5, rd_data  output  XLEN, meaning the register-file write port.
REQ-009 The block SHALL have port pending  output  32  meaning the per-register outstanding-write scoreboard.

Function
REQ-010 A source beat SHALL be accepted on a rising edge where valid and ready are both 1, and then enqueued into that source's FIFO.
REQ-011 Each ready output SHALL be 1 exactly when its FIFO count is below FIFO_DEPTH, computed from registered count only.
REQ-012 A full FIFO SHALL NOT accept a beat in the same cycle it dequeues.
REQ-013 Each cycle, at most one FIFO head SHALL be dequeued.
REQ-014 When only one FIFO is non-empty, that FIFO SHALL be dequeued.
REQ-015 When both FIFOs are non-empty, the arbiter SHALL choose round-robin: grant the source not granted last; after reset, load wins first.
REQ-016 The last_grant state SHALL update only on a cycle with a dequeue.
REQ-017 rd_addr/rd_data SHALL be registered and loaded from the dequeued head, with reg_write=1 for exactly one cycle per dequeued beat whose rd!=0.
REQ-018 A dequeued beat with rd=0 SHALL be consumed with reg_write=0 (dropped).
REQ-019 Latency SHALL be: a beat accepted at edge t into an empty block appears on the write port after edge t+1.
REQ-020 When no dequeue occurs, reg_write SHALL be 0 and rd_addr/rd_data SHALL hold their previous values.
REQ-021 Within a source, beats SHALL be written in acceptance order.
REQ-022 An issue_valid with issue_rd!=0 SHALL set pending[issue_rd] on the edge.
REQ-023 A write (reg_write asserted by that edge) SHALL clear pending[rd_addr] on the same edge.
REQ-024 When a set and a clear target the same register on the same edge, set SHALL win.
REQ-025 pending[0] SHALL always be 0.

Reset
REQ-026 On rst_n=0, asynchronously: FIFOs SHALL empty, alu_ready=load_ready=0 while asserted, reg_write=0, rd_addr=0, rd_data=0, pending=0, last_grant=ALU (so load wins first).
REQ-027 Beats in flight at reset SHALL be discarded; the first edge after deassertion SHALL accept new beats (ready=1).

Structure
REQ-028 XLEN default, REG_ADDR_W=5, NUM_REGS=32 and the source-select encoding (SRC_ALU, SRC_LOAD) SHALL live in shared package wb_pkg.
REQ-029 One sub-module wb_fifo (parameterised width/depth, count-based full/empty) SHALL be instantiated twice.

Verification
REQ-030 Single ALU beat rd=5 data=0x2A at edge t -> reg_write=1, rd_addr=5, rd_data=0x2A for one cycle after edge t+1; pending[5] cleared if previously set.
REQ-031 ALU and load valid every cycle, rd 1..8 each -> writes alternate load, ALU, load, ...; per-source order preserved; no beat lost.
REQ-032 Stall both FIFOs by holding continuous traffic with FIFO_DEPTH=2 -> ready drops to 0 after 2 unserved beats; no acceptance while ready=0.
REQ-033 Beat with rd=0 data=0xFFFF -> consumed, reg_write stays 0.
REQ-034 issue_rd=3 at edge t while a write to x3 occurs at edge t -> pending[3]=1 afterward; issue_rd=0 -> pending unchanged.
REQ-035 rst_n pulsed low mid-cycle with both FIFOs holding 2 beats -> outputs and pending go to 0 immediately; no stale writes after release.
